// File: rtl/param_return_stack.sv
// Parametrised LIFO return stack for the PC: configurable width/depth, circular or
// saturating overflow, occupancy count and sticky overflow/underflow flags.
module param_return_stack #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 16,
  parameter bit          WRAP  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             stack_in,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             stack_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    stk_ptr_q, stk_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             mem_we;
  logic [PW-1:0]    mem_waddr;
  logic [PW-1:0]    ptr_inc;
  logic [PW-1:0]    ptr_dec;
  logic             is_empty;
  logic             is_full;

  // Explicit wrap compares keep non-power-of-two depths correct.
  always_comb begin
    ptr_inc = (stk_ptr_q == PTR_MAX) ? '0 : stk_ptr_q + PW'(1);
    ptr_dec = (stk_ptr_q == '0) ? PTR_MAX : stk_ptr_q - PW'(1);
  end

  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == CNT_MAX);
  end

  // Next-state and memory write decode for one request cycle.
  always_comb begin
    stk_ptr_d   = stk_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    mem_we      = 1'b0;
    mem_waddr   = ptr_inc;

    unique case ({push, pop})
      2'b10: begin
        if (!is_full) begin
          mem_we    = 1'b1;
          stk_ptr_d = ptr_inc;
          count_d   = count_q + CW'(1);
        end else begin
          overflow_d = 1'b1;
          if (WRAP) begin
            mem_we    = 1'b1;
            stk_ptr_d = ptr_inc;
          end
        end
      end
      2'b01: begin
        if (!is_empty) begin
          stk_ptr_d = ptr_dec;
          count_d   = count_q - CW'(1);
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        if (!is_empty) begin
          // Atomic replace of the top entry; no flag effect even when full.
          mem_we    = 1'b1;
          mem_waddr = stk_ptr_q;
        end else begin
          mem_we      = 1'b1;
          stk_ptr_d   = ptr_inc;
          count_d     = CW'(1);
          underflow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stk_ptr_q   <= PTR_MAX;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      stk_ptr_q   <= stk_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[mem_waddr] <= stack_in;
    end
  end

  always_comb begin
    stack_out = is_empty ? '0 : mem[stk_ptr_q];
    count     = count_q;
    empty     = is_empty;
    full      = is_full;
    overflow  = overflow_q;
    underflow = underflow_q;
  end

endmodule

// File: tb/tb_param_return_stack.sv
// Scoreboard bench: three stack configurations driven in lockstep, compared against
// a queue-based reference model of LIFO behaviour.
module tb_param_return_stack;

  logic        clk;
  logic        reset;
  logic [10:0] stack_in;
  logic        push;
  logic        pop;
  logic        err_clr;

  logic [10:0] out0, out1;
  logic [7:0]  out2;
  logic [4:0]  cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        emp0, emp1, emp2;
  logic        ful0, ful1, ful2;
  logic        ovf0, ovf1, ovf2;
  logic        unf0, unf1, unf2;

  param_return_stack #(.WIDTH(11), .DEPTH(16), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .stack_in(stack_in), .push(push), .pop(pop),
    .err_clr(err_clr), .stack_out(out0), .count(cnt0), .empty(emp0), .full(ful0),
    .overflow(ovf0), .underflow(unf0));

  param_return_stack #(.WIDTH(11), .DEPTH(16), .WRAP(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .stack_in(stack_in), .push(push), .pop(pop),
    .err_clr(err_clr), .stack_out(out1), .count(cnt1), .empty(emp1), .full(ful1),
    .overflow(ovf1), .underflow(unf1));

  param_return_stack #(.WIDTH(8), .DEPTH(5), .WRAP(1'b1)) dut_small (
    .clk(clk), .reset(reset), .stack_in(stack_in[7:0]), .push(push), .pop(pop),
    .err_clr(err_clr), .stack_out(out2), .count(cnt2), .empty(emp2), .full(ful2),
    .overflow(ovf2), .underflow(unf2));

  typedef struct {
    int unsigned top;
    int unsigned cnt;
    bit          emp;
    bit          ful;
    bit          ovf;
    bit          unf;
  } dut_exp_t;

  typedef struct {
    dut_exp_t d0;
    dut_exp_t d1;
    dut_exp_t d2;
  } cyc_exp_t;

  cyc_exp_t    sbq[$];
  cyc_exp_t    mon_e;
  int unsigned q0[$], q1[$], q2[$];
  bit          mo0, mu0, mo1, mu1, mo2, mu2;
  int          errors = 0;
  int          checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a queue whose back is the top of stack, front is the oldest entry.
  task automatic mstep(inout int unsigned q[$], inout bit ovf, inout bit unf,
                       input int unsigned depth, input bit wrap, input int unsigned mask,
                       input bit rn, input bit ps, input bit pp, input bit clr,
                       input int unsigned d, output dut_exp_t e);
    int unsigned v;
    bit so;
    bit su;
    v  = d & mask;
    so = 1'b0;
    su = 1'b0;
    if (!rn) begin
      q.delete();
      ovf = 1'b0;
      unf = 1'b0;
    end else begin
      if (ps && pp) begin
        if (q.size() == 0) begin
          q.push_back(v);
          su = 1'b1;
        end else begin
          q[q.size()-1] = v;
        end
      end else if (ps) begin
        if (q.size() == depth) begin
          so = 1'b1;
          if (wrap) begin
            void'(q.pop_front());
            q.push_back(v);
          end
        end else begin
          q.push_back(v);
        end
      end else if (pp) begin
        if (q.size() == 0) su = 1'b1;
        else void'(q.pop_back());
      end
      ovf = so | (ovf & !clr);
      unf = su | (unf & !clr);
    end
    e.top = (q.size() != 0) ? q[q.size()-1] : 0;
    e.cnt = q.size();
    e.emp = (q.size() == 0);
    e.ful = (q.size() == depth);
    e.ovf = ovf;
    e.unf = unf;
  endtask

  // Drive one cycle at the falling edge and queue what the DUTs must show after the next rising edge.
  task automatic cyc(input bit rn, input bit ps, input bit pp, input bit clr, input int unsigned d);
    cyc_exp_t ce;
    @(negedge clk);
    reset    = rn;
    push     = ps;
    pop      = pp;
    err_clr  = clr;
    stack_in = 11'(d);
    mstep(q0, mo0, mu0, 16, 1'b1, 32'h7FF, rn, ps, pp, clr, d, ce.d0);
    mstep(q1, mo1, mu1, 16, 1'b0, 32'h7FF, rn, ps, pp, clr, d, ce.d1);
    mstep(q2, mo2, mu2, 5,  1'b1, 32'h0FF, rn, ps, pp, clr, d, ce.d2);
    sbq.push_back(ce);
    @(posedge clk);
  endtask

  function automatic void chk(string nm, logic [31:0] act, int unsigned exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void chk_dut(string tag, dut_exp_t e, logic [31:0] top, logic [31:0] cnt,
                                  logic emp, logic ful, logic ovf, logic unf);
    chk({tag, ".stack_out"}, top, e.top);
    chk({tag, ".count"}, cnt, e.cnt);
    chk({tag, ".empty"}, 32'(emp), 32'(e.emp));
    chk({tag, ".full"}, 32'(ful), 32'(e.ful));
    chk({tag, ".overflow"}, 32'(ovf), 32'(e.ovf));
    chk({tag, ".underflow"}, 32'(unf), 32'(e.unf));
  endfunction

  // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk_dut("wrap16", mon_e.d0, 32'(out0), 32'(cnt0), emp0, ful0, ovf0, unf0);
      chk_dut("sat16", mon_e.d1, 32'(out1), 32'(cnt1), emp1, ful1, ovf1, unf1);
      chk_dut("wrap5", mon_e.d2, 32'(out2), 32'(cnt2), emp2, ful2, ovf2, unf2);
    end
  end

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; stack_in = '0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);

    // Fill, then drain past empty.
    for (int i = 1; i <= 16; i++) cyc(1, 1, 0, 0, i);
    for (int i = 0; i < 17; i++) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);

    // Overflow on full stack, then drain.
    for (int i = 1; i <= 16; i++) cyc(1, 1, 0, 0, i);
    cyc(1, 1, 0, 0, 'h7FF);
    cyc(1, 1, 1, 0, 'h155);
    for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0, 0);

    // Underflow stickiness and clear priority.
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);

    // Replace-top and push+pop on empty.
    cyc(1, 1, 0, 0, 'h123);
    cyc(1, 1, 1, 0, 'h456);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 1, 1, 0, 'h0AA);
    cyc(1, 0, 0, 1, 0);

    // Reset mid-sequence beats a concurrent push.
    cyc(1, 1, 0, 0, 'h111);
    cyc(1, 1, 0, 0, 'h222);
    cyc(0, 1, 0, 0, 'h333);
    cyc(1, 1, 0, 0, 'h044);

    // Seven pushes exercise pointer wrap on the 5-deep instance.
    for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, 'h0A0 + i);
    for (int i = 0; i < 9; i++) cyc(1, 0, 1, 0, 0);

    // Randomised traffic biased toward push so full/wrap occurs often.
    for (int i = 0; i < 3000; i++) begin
      bit rn, ps, pp, clr;
      rn  = ($urandom_range(0, 59) != 0);
      ps  = ($urandom_range(0, 99) < 55);
      pp  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 8);
      cyc(rn, ps, pp, clr, $urandom & 32'h7FF);
    end

    cyc(1, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_return_stack.md
Name: param_return_stack

Overview:
- Parametrised successor to the 11-bit x 16 program-counter return stack.
- Configurable data width and depth, plus full/empty status, an occupancy count and sticky overflow/underflow flags.
- Selectable overflow mode: circular (PIC16F1826-compatible wrap) or saturating.
- Simultaneous push+pop atomically replaces the top entry. Sits between the PC logic and the CALL/RETURN/RETFIE decode.

Parameters:
- WIDTH, 11, entry width in bits (PC width).
- DEPTH, 16, number of entries; any value >= 2, not limited to powers of two.
- WRAP, 1, overflow mode: 1 = circular overwrite of the oldest entry; 0 = saturate and drop the push.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- stack_in  input  WIDTH  data to push.
- push  input  1  push request.
- pop  input  1  pop request.
- err_clr  input  1  clears the sticky overflow/underflow flags.
- stack_out  output  WIDTH  current top entry (combinational read); 0 when empty.
- count  output  CW  occupancy, where CW = clog2(DEPTH+1).
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- State:
  - stk_ptr, width clog2(DEPTH): index of the top entry.
  - count.
  - overflow, underflow flags.
  - Memory array of DEPTH x WIDTH. The memory is not reset.
- Reset (reset == 0 at a rising edge):
  - stk_ptr = DEPTH-1, count = 0, overflow = 0, underflow = 0.
  - Outputs: empty = 1, full = 0, stack_out = 0.
  - Reset has priority over all requests. A reset mid-sequence discards all entries logically.
- Pointer arithmetic:
  - inc(p) = (p == DEPTH-1) ? 0 : p+1.
  - dec(p) = (p == 0) ? DEPTH-1 : p-1.
  - Explicit compare is used, so non-power-of-two DEPTH wraps correctly.
- Read path:
  - stack_out = empty ? 0 : mem[stk_ptr].
  - Zero latency: a pushed value is visible on stack_out in the cycle after the push edge.
- Per-cycle action, with reset inactive:
  - idle (push=0, pop=0): no change.
  - push only, not full: mem[inc(stk_ptr)] <= stack_in; stk_ptr <= inc; count+1.
  - push only, full, WRAP=1: write mem[inc(stk_ptr)] and advance stk_ptr. This overwrites the oldest entry. count stays DEPTH; overflow <= 1.
  - push only, full, WRAP=0: memory, stk_ptr and count unchanged; overflow <= 1.
  - pop only, not empty: stk_ptr <= dec; count-1. Memory is untouched.
  - pop only, empty: no state change except underflow <= 1. This applies in both modes.
  - push+pop, not empty: mem[stk_ptr] <= stack_in (replace top). stk_ptr and count unchanged. No flag change, even when full.
  - push+pop, empty: behaves as push-only (count becomes 1); underflow <= 1.
- Flags:
  - Flags are sticky until err_clr = 1 or reset.
  - If a set condition and err_clr occur in the same cycle, the set wins (flag = 1).
- full, empty and count are derived from the registered count. They are never asserted simultaneously because DEPTH >= 2.
- Overflow and underflow never corrupt count: count stays within 0..DEPTH at all times.

Test Plan:
- Reset, then push 0x001..0x010 (16 pushes) -> count = 16, full = 1, stack_out = 0x010, overflow = 0. Then 16 pops -> stack_out sequence 0x010, 0x00F, ..., 0x001, then 0; empty = 1.
- WRAP=1, full with 0x001..0x010, push 0x7FF -> overflow = 1, count = 16, stack_out = 0x7FF. Then 16 pops yield 0x7FF, 0x010, ..., 0x002; 0x001 is lost. With WRAP=0, the same push leaves stack_out = 0x010 and overflow = 1.
- Empty stack, pop -> underflow = 1, count = 0, stack_out = 0. Next cycle err_clr = 1 -> underflow = 0. Then pop together with err_clr -> underflow = 1.
- Push 0x123, then push 0x456 with pop in the same cycle -> count = 1, stack_out = 0x456, no flags set. On an empty stack, push+pop of 0x0AA -> count = 1, stack_out = 0x0AA, underflow = 1.
- Push 0x111 and 0x222, assert reset = 0 together with push 0x333 -> count = 0, empty = 1, stack_out = 0, flags = 0. Then push 0x044 -> stack_out = 0x044, count = 1.
- DEPTH=5, WIDTH=8: push 7 times with WRAP=1 -> pointer wraps 4 -> 0 -> 1, count stays 5. The pop order returns the last 5 values in LIFO order.
